pulse_burst_scheduler: RTL and testbench
========================================

# pulse_burst_scheduler

Shares one programmable pulse output among `NUM_REQ` requesters. Each granted requester gets a burst of N pulses of configurable high/low length, then a one-cycle `done`. It sits above the short-pulse generation logic and sequences it. The block arbitrates round-robin, times the pulses, and reports completion.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `CNT_W`, 8, width of per-request pulse count
- `TIME_W`, 8, width of high/low duration fields

Ports:
- `clk` in 1: single clock, all logic posedge
- `rst_n` in 1: asynchronous, active-low reset
- `req` in `NUM_REQ`: level request per requester; held until its `done`
- `req_count` in `NUM_REQ*CNT_W`: packed pulse counts; slice i belongs to requester i
- `cfg_high` in `TIME_W`: pulse high duration in cycles; 0 is treated as 1
- `cfg_low` in `TIME_W`: gap between pulses in cycles; 0 is treated as 1
- `abort` in 1: terminates the active burst
- `grant` out `NUM_REQ`: one-hot owner of the current burst
- `done` out `NUM_REQ`: one-cycle completion strobe to the owner
- `busy` out 1: high in every state except IDLE
- `pulse` out 1: registered shared pulse output

## Operation
- Reset values: state=IDLE, `grant`=0, `done`=0, `busy`=0, `pulse`=0, rr pointer=0, all counters 0. Reset mid-burst drops `pulse` immediately (async).
- States:
  - IDLE: if any `req`, pick the winner by round-robin starting at the pointer.
  - Latch the winner's count, `cfg_high` and `cfg_low`. Set `grant`.
  - If the latched count ≠ 0, go to HIGH. If it is 0, go to DONE with no pulse.
  - HIGH: `pulse`=1 for H cycles. Then decrement the remaining count. If remaining = 0 go to DONE, else go to LOW.
  - LOW: `pulse`=0 for L cycles, then go to HIGH.
  - DONE: one cycle. `done[winner]`=1, `grant`=0, `pulse`=0. Pointer ← (winner+1) mod `NUM_REQ`. Then go to IDLE.
- Config and count are sampled only at grant. Changes during a burst are ignored.
- `abort` sampled high in HIGH or LOW: the next state is DONE, so `pulse` is 0 from the next edge. `abort` is ignored in IDLE and DONE.
- If `abort` and the final-high expiry occur in the same cycle, there is a single DONE.
- Requester handshake: deassert `req` by the cycle after `done`. A `req` still high in the IDLE cycle after DONE is a new request.
- `req` dropped while granted is ignored; the burst completes.
- Duration counters compare against H-1 and L-1. The pulse counter is `CNT_W` bits. A count of 2^CNT_W-1 is legal. Counters never wrap.

## Timing
- `req` sampled in IDLE at edge k: `grant` and `pulse` both go high after edge k. Latency is 1 cycle.
- Burst length with count c ≥ 1: c·H + (c−1)·L cycles of HIGH/LOW, then 1 DONE cycle, then 1 IDLE cycle.
- Minimum spacing between consecutive grants: 2 cycles after the last pulse falls.
- `grant` falls on the same edge `done` rises. `done` never overlaps `pulse`.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Package `pulse_sched_pkg`:
  - state enum {IDLE, HIGH, LOW, DONE}
  - default width constants
  - a `sat1` function mapping 0 to 1 for durations
- Sub-module `rr_arbiter`: combinational, parameterized by `NUM_REQ`.
  - Inputs: `req` vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Pointer update stays in the parent.
- Top level holds the FSM, the duration counter, the pulse counter and the output registers.

## Test plan
- Reset, then req[0]=1 with count 3, H=2, L=1: `pulse` is 110110110, then `done[0]` rises one cycle after the last high. `grant[0]` is high for the 9 cycles.
- All four `req` high, count 1, H=1, L=1: grants in order 0,1,2,3,0. Each `done` maps to its own index.
- req[2] with count 0: `grant[2]` for one cycle, `done[2]` the next cycle, `pulse` never high.
- `cfg_high`=0, `cfg_low`=0, count 2: behaves as H=1, L=1, giving `pulse` 101.
- `abort` in the 2nd high cycle of a count-5, H=4 burst: `pulse` is low from the next edge, followed by one `done` and IDLE. The pointer still advances.
- `rst_n` asserted during LOW and released 3 cycles later: all outputs 0 asynchronously. The pointer returns to 0 and a pending req[1] is granted after release.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse burst scheduler.
// Holds the FSM state encoding, the default widths and the duration saturation helper.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StDone
    } state_e;

    localparam int unsigned DefNumReq = 4;
    localparam int unsigned DefCntW   = 8;
    localparam int unsigned DefTimeW  = 8;

    // A programmed duration of 0 behaves as a single cycle.
    function automatic logic [31:0] sat1(input logic [31:0] val);
        return (val == 32'd0) ? 32'd1 : val;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at i_ptr and wraps. The parent owns the pointer update.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    logic w_found;
    int   w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_pos = int'(i_ptr) + i;
            if (w_pos >= int'(NUM_REQ)) begin
                w_pos = w_pos - int'(NUM_REQ);
            end
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Shares one registered pulse output among NUM_REQ requesters.
// Each winner gets a burst of N high/low pulses, followed by a one-cycle done strobe.
module pulse_burst_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned TIME_W  = DefTimeW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_count,
    input  logic [TIME_W-1:0]        cfg_high,
    input  logic [TIME_W-1:0]        cfg_low,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     pulse
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_e               r_state,  w_state_nxt;
    logic [TIME_W-1:0]    r_dur,    w_dur_nxt;
    logic [CNT_W-1:0]     r_rem,    w_rem_nxt;
    logic [TIME_W-1:0]    r_high,   w_high_nxt;
    logic [TIME_W-1:0]    r_low,    w_low_nxt;
    logic [IDX_W-1:0]     r_owner,  w_owner_nxt;
    logic [IDX_W-1:0]     r_ptr,    w_ptr_nxt;
    logic [NUM_REQ-1:0]   r_grant,  w_grant_nxt;
    logic [NUM_REQ-1:0]   r_done,   w_done_nxt;
    logic                 r_busy;
    logic                 r_pulse;

    logic [NUM_REQ-1:0]   w_arb_grant;
    logic [IDX_W-1:0]     w_arb_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_dur_nxt   = r_dur;
        w_rem_nxt   = r_rem;
        w_high_nxt  = r_high;
        w_low_nxt   = r_low;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        unique case (r_state)
            StIdle: begin
                if (|req) begin
                    w_owner_nxt = w_arb_idx;
                    w_grant_nxt = w_arb_grant;
                    w_rem_nxt   = req_count[int'(w_arb_idx)*int'(CNT_W) +: CNT_W];
                    w_high_nxt  = TIME_W'(sat1(32'(cfg_high)));
                    w_low_nxt   = TIME_W'(sat1(32'(cfg_low)));
                    w_dur_nxt   = '0;
                    w_state_nxt = (w_rem_nxt != '0) ? StHigh : StDone;
                end
            end
            StHigh: begin
                if (abort) begin
                    w_state_nxt = StDone;
                end else if (r_dur == r_high - TIME_W'(1)) begin
                    w_dur_nxt   = '0;
                    w_rem_nxt   = r_rem - CNT_W'(1);
                    w_state_nxt = (r_rem == CNT_W'(1)) ? StDone : StLow;
                end else begin
                    w_dur_nxt = r_dur + TIME_W'(1);
                end
            end
            StLow: begin
                if (abort) begin
                    w_state_nxt = StDone;
                end else if (r_dur == r_low - TIME_W'(1)) begin
                    w_dur_nxt   = '0;
                    w_state_nxt = StHigh;
                end else begin
                    w_dur_nxt = r_dur + TIME_W'(1);
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                w_done_nxt  = r_grant;
                w_grant_nxt = '0;
                w_ptr_nxt   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Output registers are loaded from next-state so they align with the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_dur   <= '0;
            r_rem   <= '0;
            r_high  <= '0;
            r_low   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dur   <= w_dur_nxt;
            r_rem   <= w_rem_nxt;
            r_high  <= w_high_nxt;
            r_low   <= w_low_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != StIdle);
            r_pulse <= (w_state_nxt == StHigh);
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;
    assign pulse = r_pulse;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Directed bench for pulse_burst_scheduler with hand-computed cycle-by-cycle expectations.
// Outputs are sampled 1 time unit after each rising edge.
module tb_pulse_burst_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIME_W  = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_count;
    logic [TIME_W-1:0]        cfg_high;
    logic [TIME_W-1:0]        cfg_low;
    logic                     abort;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     pulse;

    int n_checks = 0;
    int n_errors = 0;

    pulse_burst_scheduler #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W),
        .TIME_W  (TIME_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_count (req_count),
        .cfg_high  (cfg_high),
        .cfg_low   (cfg_low),
        .abort     (abort),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .pulse     (pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pulse"}, 32'(pulse), 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_done"},  32'(done),  32'd0);
        check({tag, "_busy"},  32'(busy),  32'd0);
    endtask

    logic [8:0] pat1;
    logic [3:0] pat4;
    int         e;

    initial begin
        req       = '0;
        req_count = '0;
        cfg_high  = '0;
        cfg_low   = '0;
        abort     = 1'b0;
        do_reset();
        check_idle("reset");

        // Count 3, H=2, L=1 on requester 0.
        pat1      = 9'b110110110;
        req       = 4'b0001;
        req_count = {8'd0, 8'd0, 8'd0, 8'd3};
        cfg_high  = 8'd2;
        cfg_low   = 8'd1;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("t1_pulse%0d", i), 32'(pulse), 32'(pat1[8-i]));
            check($sformatf("t1_grant%0d", i), 32'(grant), 32'b0001);
            check($sformatf("t1_done%0d", i), 32'(done), 32'd0);
        end
        step();
        check("t1_done", 32'(done), 32'b0001);
        check("t1_grant_off", 32'(grant), 32'd0);
        check("t1_pulse_off", 32'(pulse), 32'd0);
        req = '0;
        step();
        check_idle("t1_after");

        // Round-robin with all four requesting, from a fresh pointer.
        do_reset();
        req       = 4'b1111;
        req_count = {8'd1, 8'd1, 8'd1, 8'd1};
        cfg_high  = 8'd1;
        cfg_low   = 8'd1;
        for (int g = 0; g < 5; g++) begin
            e = g % 4;
            step();
            check($sformatf("t2_grant_hi%0d", g), 32'(grant), 32'(1) << e);
            check($sformatf("t2_pulse_hi%0d", g), 32'(pulse), 32'd1);
            step();
            check($sformatf("t2_grant_dn%0d", g), 32'(grant), 32'(1) << e);
            check($sformatf("t2_pulse_dn%0d", g), 32'(pulse), 32'd0);
            step();
            check($sformatf("t2_grant_id%0d", g), 32'(grant), 32'd0);
            check($sformatf("t2_done%0d", g), 32'(done), 32'(1) << e);
        end
        req = '0;

        // Zero count on requester 2: grant, then done, no pulse.
        req       = 4'b0100;
        req_count = '0;
        step();
        check("t3_grant", 32'(grant), 32'b0100);
        check("t3_pulse", 32'(pulse), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        step();
        check("t3_grant_off", 32'(grant), 32'd0);
        check("t3_done", 32'(done), 32'b0100);
        check("t3_pulse2", 32'(pulse), 32'd0);
        req = '0;
        step();
        check_idle("t3_after");

        // Zero durations saturate to one cycle.
        pat4      = 4'b1010;
        req       = 4'b1000;
        req_count = {8'd2, 8'd0, 8'd0, 8'd0};
        cfg_high  = 8'd0;
        cfg_low   = 8'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t4_pulse%0d", i), 32'(pulse), 32'(pat4[3-i]));
            check($sformatf("t4_grant%0d", i), 32'(grant), 32'b1000);
        end
        step();
        check("t4_done", 32'(done), 32'b1000);
        req = '0;
        step();

        // Abort in the second high cycle of a count-5, H=4 burst.
        req       = 4'b0001;
        req_count = {8'd0, 8'd0, 8'd0, 8'd5};
        cfg_high  = 8'd4;
        cfg_low   = 8'd1;
        step();
        check("t5_pulse0", 32'(pulse), 32'd1);
        step();
        check("t5_pulse1", 32'(pulse), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_pulse_ab", 32'(pulse), 32'd0);
        check("t5_grant_ab", 32'(grant), 32'b0001);
        step();
        check("t5_done", 32'(done), 32'b0001);
        check("t5_grant_off", 32'(grant), 32'd0);
        req = '0;
        step();
        check_idle("t5_after");

        // Pointer advanced to 1; config is latched at grant.
        req       = 4'b0011;
        req_count = {8'd0, 8'd0, 8'd3, 8'd1};
        cfg_high  = 8'd2;
        cfg_low   = 8'd3;
        step();
        check("t6_grant_ptr", 32'(grant), 32'b0010);
        check("t6_pulse0", 32'(pulse), 32'd1);
        cfg_high = 8'd5;
        step();
        check("t6_pulse1", 32'(pulse), 32'd1);
        step();
        check("t6_pulse_low", 32'(pulse), 32'd0);

        // Asynchronous reset in the middle of LOW.
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("t6_async");
        req = 4'b0010;
        repeat (3) @(posedge clk);
        #1;
        check_idle("t6_held");
        rst_n = 1'b1;
        step();
        check("t6_grant_rel", 32'(grant), 32'b0010);
        check("t6_pulse_rel", 32'(pulse), 32'd1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t6_pulse_ab", 32'(pulse), 32'd0);
        step();
        check("t6_done", 32'(done), 32'b0010);
        req = '0;
        step();
        check_idle("t6_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
